// File: rtl/rvvi_frame_unpacker_if.sv
// Bus bundle between the trace receive logic (master) and the RVVI frame
// unpacker (slave): frame input channel, header output channel, CSR output
// channel.
//
// Handshake semantics (all three channels): a beat transfers on a rising
// clock edge where valid and ready are both high. Once valid is raised it
// stays high, with its payload unchanged, until that transfer happens.
// Ready may be raised or lowered at any time.
interface rvvi_frame_unpacker_if #(
  parameter int XLEN              = 64,
  parameter int MAX_CSRS          = 5,
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int RVVI_WIDTH        = 128 + 4*XLEN + MAX_CSRS*(XLEN+16)
);
  // frame channel
  logic                         FrameValid;
  logic                         FrameReady;
  logic [RVVI_WIDTH-1:0]        Frame;
  logic [FRAME_COUNT_WIDTH-1:0] FrameCount;
  // header channel
  logic                         HdrValid;
  logic                         HdrReady;
  logic [XLEN-1:0]              PC;
  logic [63:0]                  Mcycle;
  logic [63:0]                  Minstret;
  logic [31:0]                  Instr;
  logic                         Trap;
  logic [1:0]                   PrivMode;
  logic                         GPRWen;
  logic                         FPRWen;
  logic [4:0]                   GPRAddr;
  logic [4:0]                   FPRAddr;
  logic [XLEN-1:0]              RegValue;
  logic [3:0]                   CSRCount;
  // CSR channel
  logic                         CsrValid;
  logic                         CsrReady;
  logic [11:0]                  CsrAddr;
  logic [XLEN-1:0]              CsrValue;
  logic                         CsrLast;
  // status
  logic                         SeqErr;
  logic                         CountErr;
  logic [15:0]                  GapCount;

  modport master (
    output FrameValid, Frame, FrameCount, HdrReady, CsrReady,
    input  FrameReady, HdrValid, PC, Mcycle, Minstret, Instr, Trap, PrivMode,
           GPRWen, FPRWen, GPRAddr, FPRAddr, RegValue, CSRCount,
           CsrValid, CsrAddr, CsrValue, CsrLast, SeqErr, CountErr, GapCount
  );

  modport slave (
    input  FrameValid, Frame, FrameCount, HdrReady, CsrReady,
    output FrameReady, HdrValid, PC, Mcycle, Minstret, Instr, Trap, PrivMode,
           GPRWen, FPRWen, GPRAddr, FPRAddr, RegValue, CSRCount,
           CsrValid, CsrAddr, CsrValue, CsrLast, SeqErr, CountErr, GapCount
  );
endinterface

// File: rtl/rvvi_frame_unpacker.sv
// RVVI frame unpacker: latches one packed trace frame, presents its header
// in one beat, then streams the CSR write list one (addr, value) per beat.
// Also checks frame sequence continuity and clamps oversized CSR counts.
module rvvi_frame_unpacker #(
  parameter int XLEN              = 64,
  parameter int MAX_CSRS          = 5,
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int RVVI_WIDTH        = 128 + 4*XLEN + MAX_CSRS*(XLEN+16)
) (
  input  logic                  clk,
  input  logic                  reset,
  rvvi_frame_unpacker_if.slave  bus,
  output logic [1:0]            dbg_state
);

  // Frame field offsets
  localparam int R           = 128 + 3*XLEN;
  localparam int CNT_LO      = XLEN + 160;
  localparam int CSR_VAL_LO  = R + XLEN;
  localparam int CSR_ADDR_LO = R + XLEN + MAX_CSRS*XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_CSR  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [RVVI_WIDTH-1:0]        frame_q, frame_d;
  logic [3:0]                   idx_q, idx_d;
  logic                         first_seen_q, first_seen_d;
  logic [FRAME_COUNT_WIDTH-1:0] exp_cnt_q, exp_cnt_d;
  logic                         seq_err_q, seq_err_d;
  logic                         count_err_q, count_err_d;
  logic [15:0]                  gap_q, gap_d;

  logic [11:0]     raw_cnt_latched;
  logic [11:0]     raw_cnt_in;
  logic [3:0]      csr_count;
  logic            csr_last;
  logic [11:0]     csr_addr_sel;
  logic [XLEN-1:0] csr_val_sel;
  logic            frame_ready;
  logic            hdr_valid;
  logic            csr_valid;
  logic            csr_last_out;

  assign raw_cnt_latched = frame_q[CNT_LO +: 12];
  assign raw_cnt_in      = bus.Frame[CNT_LO +: 12];
  assign csr_count       = (raw_cnt_latched > 12'(MAX_CSRS)) ? 4'(MAX_CSRS)
                                                             : raw_cnt_latched[3:0];
  assign csr_last        = (idx_q == (csr_count - 4'd1));

  // Header fields come straight from the latched frame, so they hold while stalled
  assign bus.PC       = frame_q[XLEN-1:0];
  assign bus.Mcycle   = frame_q[XLEN +: 64];
  assign bus.Minstret = frame_q[XLEN+64 +: 64];
  assign bus.Instr    = frame_q[XLEN+128 +: 32];
  assign bus.Trap     = frame_q[XLEN+176];
  assign bus.PrivMode = frame_q[XLEN+184 +: 2];
  assign bus.GPRWen   = frame_q[XLEN+192];
  assign bus.FPRWen   = frame_q[XLEN+200];
  assign bus.GPRAddr  = frame_q[XLEN+208 +: 5];
  assign bus.FPRAddr  = frame_q[XLEN+216 +: 5];
  assign bus.RegValue = frame_q[R +: XLEN];
  assign bus.CSRCount = csr_count;

  assign bus.CsrAddr    = csr_addr_sel;
  assign bus.CsrValue   = csr_val_sel;
  assign bus.FrameReady = frame_ready;
  assign bus.HdrValid   = hdr_valid;
  assign bus.CsrValid   = csr_valid;
  assign bus.CsrLast    = csr_last_out;
  assign bus.SeqErr     = seq_err_q;
  assign bus.CountErr   = count_err_q;
  assign bus.GapCount   = gap_q;
  assign dbg_state      = state_q;

  // Select the CSR slot addressed by the beat index; upper 4 bits of each
  // 16-bit address field are pad and dropped
  always_comb begin
    csr_addr_sel = '0;
    csr_val_sel  = '0;
    for (int i = 0; i < MAX_CSRS; i++) begin
      if (idx_q == 4'(i)) begin
        csr_val_sel  = frame_q[CSR_VAL_LO + i*XLEN +: XLEN];
        csr_addr_sel = frame_q[CSR_ADDR_LO + i*16 +: 12];
      end
    end
  end

  // Next-state, handshake outputs, frame capture and sequence check
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    idx_d        = idx_q;
    first_seen_d = first_seen_q;
    exp_cnt_d    = exp_cnt_q;
    seq_err_d    = seq_err_q;
    count_err_d  = count_err_q;
    gap_d        = gap_q;
    frame_ready  = 1'b0;
    hdr_valid    = 1'b0;
    csr_valid    = 1'b0;
    csr_last_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        frame_ready = 1'b1;
        if (bus.FrameValid) begin
          frame_d = bus.Frame;
          idx_d   = '0;
          state_d = S_HDR;
          if (raw_cnt_in > 12'(MAX_CSRS)) count_err_d = 1'b1;
          // The first frame after reset only seeds the expected count
          if (first_seen_q && (bus.FrameCount != exp_cnt_q)) begin
            seq_err_d = 1'b1;
            if (gap_q != 16'hFFFF) gap_d = gap_q + 16'd1;
          end
          first_seen_d = 1'b1;
          exp_cnt_d    = bus.FrameCount + 1'b1;
        end
      end
      S_HDR: begin
        hdr_valid = 1'b1;
        if (bus.HdrReady) begin
          idx_d   = '0;
          state_d = (csr_count == 4'd0) ? S_IDLE : S_CSR;
        end
      end
      S_CSR: begin
        csr_valid    = 1'b1;
        csr_last_out = csr_last;
        if (bus.CsrReady) begin
          if (csr_last) state_d = S_IDLE;
          else          idx_d   = idx_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; async reset discards any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      frame_q      <= '0;
      idx_q        <= '0;
      first_seen_q <= 1'b0;
      exp_cnt_q    <= '0;
      seq_err_q    <= 1'b0;
      count_err_q  <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      idx_q        <= idx_d;
      first_seen_q <= first_seen_d;
      exp_cnt_q    <= exp_cnt_d;
      seq_err_q    <= seq_err_d;
      count_err_q  <= count_err_d;
      gap_q        <= gap_d;
    end
  end

endmodule

// File: tb/tb_rvvi_frame_unpacker.sv
// Directed testbench for rvvi_frame_unpacker. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_rvvi_frame_unpacker;

  localparam int W = 784;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  rvvi_frame_unpacker_if bus ();

  rvvi_frame_unpacker dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fr;
  logic [75:0]  exp_q[$];   // {addr[11:0], value[63:0]} per expected CSR beat

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // frame building
  task automatic set_hdr(input logic [63:0] pc, input logic [31:0] instr,
                         input logic gwen, input logic [4:0] gaddr,
                         input logic [63:0] regval, input logic [11:0] raw);
    fr = '0;
    fr[63:0]    = pc;
    fr[127:64]  = 64'h0000_0000_0000_1000;  // Mcycle
    fr[191:128] = 64'h0000_0000_0000_0800;  // Minstret
    fr[223:192] = instr;
    fr[235:224] = raw;
    fr[249:248] = 2'b11;                    // PrivMode
    fr[256]     = gwen;
    fr[276:272] = gaddr;
    fr[383:320] = regval;
  endtask

  task automatic set_slot(input int i, input logic [11:0] addr, input logic [63:0] val,
                          input bit expect_beat);
    fr[384 + 64*i +: 64] = val;
    fr[704 + 16*i +: 16] = {4'hF, addr};    // pad nibble must be ignored
    if (expect_beat) exp_q.push_back({addr, val});
  endtask

  // drivers
  task automatic accept(input logic [15:0] count);
    int n = 0;
    while (!bus.FrameReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("frame_ready_wait", {63'd0, bus.FrameReady}, 64'd1);
    bus.FrameValid = 1'b1;
    bus.Frame      = fr;
    bus.FrameCount = count;
    @(negedge clk);
    bus.FrameValid = 1'b0;
    bus.Frame      = '0;
    chk("hdr_valid_t1", {63'd0, bus.HdrValid}, 64'd1);
  endtask

  task automatic take_hdr();
    bus.HdrReady = 1'b1;
    @(negedge clk);
    bus.HdrReady = 1'b0;
  endtask

  task automatic drain_csr(input int n, input bit toggle);
    int k   = 0;
    int cyc = 0;
    logic rdy;
    logic [75:0] head;
    while (k < n && cyc < 100) begin
      cyc++;
      head = exp_q[0];
      chk("csr_valid", {63'd0, bus.CsrValid}, 64'd1);
      chk("frame_ready_busy", {63'd0, bus.FrameReady}, 64'd0);
      chk("csr_addr", {52'd0, bus.CsrAddr}, {52'd0, head[75:64]});
      chk("csr_value", bus.CsrValue, head[63:0]);
      chk("csr_last", {63'd0, bus.CsrLast}, {63'd0, (k == n-1)});
      rdy = toggle ? cyc[0] == 1'b0 : 1'b1;
      bus.CsrReady = rdy;
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        k++;
      end
    end
    bus.CsrReady = 1'b0;
    if (k < n) chk("csr_timeout", 64'(k), 64'(n));
    chk("frame_ready_after", {63'd0, bus.FrameReady}, 64'd1);
    chk("csr_valid_after", {63'd0, bus.CsrValid}, 64'd0);
  endtask

  // directed sequence
  initial begin
    reset          = 1'b0;
    bus.FrameValid = 1'b0;
    bus.Frame      = '0;
    bus.FrameCount = '0;
    bus.HdrReady   = 1'b0;
    bus.CsrReady   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frame_ready", {63'd0, bus.FrameReady}, 64'd1);
    chk("rst_hdr_valid", {63'd0, bus.HdrValid}, 64'd0);
    chk("rst_pc", bus.PC, 64'd0);
    chk("rst_gap", {48'd0, bus.GapCount}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: simple header-only frame, seq 0xFFFE (first frame)
    set_hdr(64'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 64'd5, 12'd0);
    accept(16'hFFFE);
    chk("t1_pc", bus.PC, 64'h8000_0000);
    chk("t1_instr", {32'd0, bus.Instr}, 64'h0050_0093);
    chk("t1_gprwen", {63'd0, bus.GPRWen}, 64'd1);
    chk("t1_gpraddr", {59'd0, bus.GPRAddr}, 64'd1);
    chk("t1_regvalue", bus.RegValue, 64'd5);
    chk("t1_mcycle", bus.Mcycle, 64'h1000);
    chk("t1_minstret", bus.Minstret, 64'h800);
    chk("t1_priv", {62'd0, bus.PrivMode}, 64'd3);
    chk("t1_trap", {63'd0, bus.Trap}, 64'd0);
    chk("t1_fprwen", {63'd0, bus.FPRWen}, 64'd0);
    chk("t1_csrcount", {60'd0, bus.CSRCount}, 64'd0);
    chk("t1_frame_ready_busy", {63'd0, bus.FrameReady}, 64'd0);
    take_hdr();
    chk("t1_frame_ready_2cyc", {63'd0, bus.FrameReady}, 64'd1);
    chk("t1_no_csr", {63'd0, bus.CsrValid}, 64'd0);

    // 2: three CSRs, ready held high, seq 0xFFFF
    set_hdr(64'h8000_0004, 32'h3000_2073, 1'b0, 5'd0, 64'd0, 12'd3);
    set_slot(0, 12'h300, 64'h8, 1'b1);
    set_slot(1, 12'h341, 64'h8000_0004, 1'b1);
    set_slot(2, 12'h342, 64'hB, 1'b1);
    accept(16'hFFFF);
    chk("t2_csrcount", {60'd0, bus.CSRCount}, 64'd3);
    take_hdr();
    drain_csr(3, 1'b0);
    chk("t2_count_err", {63'd0, bus.CountErr}, 64'd0);

    // 3: raw count 7 clamps to 5, seq 0x0000 (wrap, no error)
    set_hdr(64'h8000_0008, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 12'd7);
    for (int i = 0; i < 5; i++) set_slot(i, 12'(12'h001 + i), 64'(64'h1111 * (i + 1)), 1'b1);
    accept(16'h0000);
    chk("t3_count_err", {63'd0, bus.CountErr}, 64'd1);
    chk("t3_csrcount", {60'd0, bus.CSRCount}, 64'd5);
    take_hdr();
    drain_csr(5, 1'b0);
    chk("t3_seq_err_wrap", {63'd0, bus.SeqErr}, 64'd0);
    chk("t3_gap_wrap", {48'd0, bus.GapCount}, 64'd0);

    // 4: seq 0x0002 skips 0x0001
    set_hdr(64'h8000_000C, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 12'd0);
    accept(16'h0002);
    chk("t4_seq_err", {63'd0, bus.SeqErr}, 64'd1);
    chk("t4_gap", {48'd0, bus.GapCount}, 64'd1);
    take_hdr();

    // 5: stalls; seq 0x0003 continuous
    set_hdr(64'h8000_0010, 32'h0000_0073, 1'b0, 5'd0, 64'd0, 12'd2);
    set_slot(0, 12'h7C0, 64'hDEAD, 1'b1);
    set_slot(1, 12'h7C1, 64'hBEEF, 1'b1);
    accept(16'h0003);
    chk("t5_gap_hold", {48'd0, bus.GapCount}, 64'd1);
    chk("t5_count_err_sticky", {63'd0, bus.CountErr}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_hdr_stall_valid", {63'd0, bus.HdrValid}, 64'd1);
      chk("t5_hdr_stall_pc", bus.PC, 64'h8000_0010);
      chk("t5_hdr_stall_ready", {63'd0, bus.FrameReady}, 64'd0);
    end
    take_hdr();
    drain_csr(2, 1'b1);

    // 6: reset while at CSR index 1
    set_hdr(64'h8000_0014, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 12'd3);
    set_slot(0, 12'h100, 64'hA0, 1'b0);
    set_slot(1, 12'h101, 64'hA1, 1'b0);
    set_slot(2, 12'h102, 64'hA2, 1'b0);
    accept(16'h0004);
    take_hdr();
    bus.CsrReady = 1'b1;
    @(negedge clk);
    bus.CsrReady = 1'b0;
    chk("t6_idx1_addr", {52'd0, bus.CsrAddr}, 64'h101);
    reset = 1'b0;
    #1;
    chk("t6_rst_frame_ready", {63'd0, bus.FrameReady}, 64'd1);
    chk("t6_rst_csr_valid", {63'd0, bus.CsrValid}, 64'd0);
    chk("t6_rst_csr_last", {63'd0, bus.CsrLast}, 64'd0);
    chk("t6_rst_csr_addr", {52'd0, bus.CsrAddr}, 64'd0);
    chk("t6_rst_csr_value", bus.CsrValue, 64'd0);
    chk("t6_rst_seq_err", {63'd0, bus.SeqErr}, 64'd0);
    chk("t6_rst_count_err", {63'd0, bus.CountErr}, 64'd0);
    chk("t6_rst_gap", {48'd0, bus.GapCount}, 64'd0);
    chk("t6_rst_pc", bus.PC, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 7: first frame after reset, arbitrary seq; then continuous follow-up
    set_hdr(64'h8000_0100, 32'h0000_0013, 1'b0, 5'd0, 64'd0, 12'd0);
    accept(16'h1234);
    chk("t7_first_seq_err", {63'd0, bus.SeqErr}, 64'd0);
    take_hdr();
    accept(16'h1235);
    chk("t7_cont_seq_err", {63'd0, bus.SeqErr}, 64'd0);
    chk("t7_cont_gap", {48'd0, bus.GapCount}, 64'd0);
    take_hdr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvvi_frame_unpacker.md
Name: rvvi_frame_unpacker

Overview:
- Receiving end of the compressed RVVI trace frame produced by the core-side rvvi probe.
- Accepts one packed frame at a time over a valid/ready handshake and checks frame-count continuity.
- Presents the fixed header fields in one beat, then serializes the variable-length CSR write list one (address, value) pair per beat.
- Sits in the host/checker side of the trace path, for example behind the Ethernet/FIFO receive logic, feeding a lockstep comparator.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported; the frame layout below assumes it.
- MAX_CSRS, 5, CSR slots per frame.
- RVVI_WIDTH, 128+4*XLEN+MAX_CSRS*(XLEN+16), packed frame width.
- FRAME_COUNT_WIDTH, 16, width of the frame sequence number.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- FrameValid  in  1  input frame available.
- FrameReady  out  1  unpacker can accept a frame.
- Frame  in  RVVI_WIDTH  packed frame.
- FrameCount  in  FRAME_COUNT_WIDTH  sender sequence number for this frame.
- HdrValid  out  1  header beat valid.
- HdrReady  in  1  header beat consumed.
- PC, Mcycle, Minstret  out  XLEN/64/64  header fields.
- Instr  out  32  header field.
- Trap  out  1  header field.
- PrivMode  out  2  header field.
- GPRWen, FPRWen  out  1 each  header fields.
- GPRAddr, FPRAddr  out  5 each  header fields.
- RegValue  out  XLEN  register write data.
- CSRCount  out  4  CSR entries that will be emitted, after clamping.
- CsrValid  out  1  CSR beat valid.
- CsrReady  in  1  CSR beat consumed.
- CsrAddr  out  12  CSR address.
- CsrValue  out  XLEN  CSR value.
- CsrLast  out  1  final CSR beat of this frame.
- SeqErr  out  1  sticky: a frame-count discontinuity was seen.
- CountErr  out  1  sticky: a frame's CSR count exceeded MAX_CSRS.
- GapCount  out  16  saturating count of discontinuities.

Behaviour:
- Frame layout, bit offsets with X=XLEN:
  - PC [X-1:0], Mcycle [X+63:X], Minstret [X+127:X+64], Instr [X+159:X+128].
  - Raw CSR count [X+171:X+160]; Trap bit X+176; PrivMode [X+185:X+184].
  - GPRWen bit X+192; FPRWen bit X+200; GPRAddr [X+212:X+208]; FPRAddr [X+220:X+216].
  - Define R=128+3X. RegValue [R+X-1:R].
  - CSR value i at [R+X+(i+1)X-1 : R+X+iX].
  - CSR address i at bits [11:0] of the 16-bit field at R+X+MAX_CSRS*X+16i.
  - Pad bits are ignored.
- State machine IDLE → HDR → CSR → IDLE.
  - IDLE: FrameReady=1. When FrameValid is high, the whole frame is latched and the next state is HDR.
  - HDR: HdrValid=1 and the header outputs are stable until HdrReady. On handshake, go to IDLE if CSRCount==0, else go to CSR with index=0.
  - CSR: CsrValid=1; CsrAddr and CsrValue come from slot index; CsrLast=(index==CSRCount-1). On handshake, increment index; after the last beat go to IDLE.
- Timing:
  - Accept at edge t puts HdrValid high from t+1.
  - Back-to-back handshakes give one header beat per cycle and one CSR beat per cycle.
  - FrameReady rises the cycle after the final beat. A full frame therefore takes at least 2+CSRCount cycles.
- FrameReady and the latched frame do not depend combinationally on the Hdr/Csr ready inputs.
- CSR count clamp: if the raw count exceeds MAX_CSRS, CSRCount=MAX_CSRS and CountErr is set (sticky).
- Sequence check, evaluated at accept:
  - The first frame after reset initializes the expected value only.
  - Afterwards, if FrameCount differs from expected, SeqErr is set (sticky) and GapCount increments, saturating at 0xFFFF.
  - Expected then becomes FrameCount+1, wrapping modulo 2^FRAME_COUNT_WIDTH. A wrap from 0xFFFF to 0x0000 is not an error.
- Reset (asynchronous assert, any state, including mid-frame) clears:
  - state to IDLE, so FrameReady=1 after release;
  - HdrValid, CsrValid, CsrLast, SeqErr, CountErr and GapCount to 0;
  - the latched frame and all header/CSR outputs to 0;
  - the first-frame flag.
  - A frame in flight is discarded.
- Valid outputs never drop without a handshake, and payload outputs are held while stalled.

Test Plan:
- Frame with PC=0x80000000, Instr=0x00500093, GPRWen=1, GPRAddr=1, RegValue=5, count=0 → one header beat with exactly those values; no CsrValid; FrameReady high 2 cycles after accept.
- Count=3 with slots (0x300,0x8), (0x341,0x80000004), (0x342,0xB), CsrReady held 1 → 3 consecutive CSR beats in slot order; CsrLast only on 0x342.
- Raw count=7 with MAX_CSRS=5 → exactly 5 CSR beats and CountErr=1.
- FrameCount sequence 0xFFFE, 0xFFFF, 0x0000, 0x0002 → one gap detected: SeqErr=1 and GapCount=1, both only after the 0x0002 frame.
- HdrReady low for 4 cycles, then CsrReady toggling → header and CSR outputs stable while stalled; no beats lost or duplicated; FrameReady stays 0 until the last beat.
- Reset asserted during the CSR state at index 1 → immediate IDLE with all outputs 0; after release the next frame is accepted as a first frame, with no SeqErr.
